// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if
//   Bundles the two writeback requester channels and the register-file
//   write port into one interface.
//   slave  modport : arbiter side (takes requests, drives RW/BusW/RegWr).
//   master modport : requester / environment side.
//   Signals:
//     ReqValid0/1, ReqAddr0/1, ReqData0/1 : requester write offers
//     ReqReady0/1                         : requester queue can accept
//     RW, BusW, RegWr                     : register-file write port
//     Pending                             : one bit per register, write outstanding
//     Idle                                : nothing queued and no write in flight
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  localparam int NREG = 1 << ADDR_W;

  logic              ReqValid0;
  logic              ReqReady0;
  logic [ADDR_W-1:0] ReqAddr0;
  logic [DATA_W-1:0] ReqData0;
  logic              ReqValid1;
  logic              ReqReady1;
  logic [ADDR_W-1:0] ReqAddr1;
  logic [DATA_W-1:0] ReqData1;
  logic [ADDR_W-1:0] RW;
  logic [DATA_W-1:0] BusW;
  logic              RegWr;
  logic [NREG-1:0]   Pending;
  logic              Idle;

  modport slave (
    input  ReqValid0, ReqAddr0, ReqData0,
    input  ReqValid1, ReqAddr1, ReqData1,
    output ReqReady0, ReqReady1,
    output RW, BusW, RegWr, Pending, Idle
  );

  modport master (
    output ReqValid0, ReqAddr0, ReqData0,
    output ReqValid1, ReqAddr1, ReqData1,
    input  ReqReady0, ReqReady1,
    input  RW, BusW, RegWr, Pending, Idle
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between two writeback
//   requesters. Each requester feeds a small FIFO; one queued write is
//   drained per cycle under round-robin arbitration. Writes addressed to
//   the zero register are accepted and dropped. A pending-write bitmask is
//   exported so decode can stall on read-after-write hazards.
//   Ports:
//     Clk   : clock, all state updates on the rising edge
//     Reset : synchronous, active-high
//     bus   : regfile_write_arbiter_if.slave (requests, RW/BusW/RegWr,
//             Pending, Idle)
module regfile_write_arbiter #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int ZERO_REG   = 31
) (
  input  logic Clk,
  input  logic Reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NREG  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

  // Queue storage and state
  logic [ADDR_W-1:0] q_addr [2][FIFO_DEPTH];
  logic [DATA_W-1:0] q_data [2][FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_r [2];
  logic [PTR_W-1:0]  rptr_r [2];
  logic [PTR_W:0]    cnt_r  [2];
  // Requester that wins the next two-way contention
  logic              rr_r;
  // Registered write-port outputs
  logic [ADDR_W-1:0] rw_r;
  logic [DATA_W-1:0] busw_r;
  logic              regwr_r;

  logic [1:0]        req_valid;
  logic [ADDR_W-1:0] req_addr [2];
  logic [DATA_W-1:0] req_data [2];
  logic [1:0]        full_s;
  logic [1:0]        nonempty_s;
  logic [1:0]        ready_s;
  logic [1:0]        push_s;
  logic [1:0]        pop_s;
  logic              gnt_any_s;
  logic              gnt_sel_s;
  logic [NREG-1:0]   pending_s;

  assign req_valid[0] = bus.ReqValid0;
  assign req_valid[1] = bus.ReqValid1;
  assign req_addr[0]  = bus.ReqAddr0;
  assign req_addr[1]  = bus.ReqAddr1;
  assign req_data[0]  = bus.ReqData0;
  assign req_data[1]  = bus.ReqData1;

  // Queue status, handshake and zero-register filtering
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      full_s[n]     = (cnt_r[n] == FULL_CNT);
      nonempty_s[n] = (cnt_r[n] != '0);
      // Fullness is taken before this edge's pop, so a full queue never
      // accepts in the cycle it drains.
      ready_s[n]    = !Reset && !full_s[n];
      push_s[n]     = req_valid[n] && ready_s[n] && (req_addr[n] != ZERO_ADDR);
    end
  end

  // Round-robin grant selection
  always_comb begin
    gnt_any_s = nonempty_s[0] | nonempty_s[1];
    if (nonempty_s[0] && nonempty_s[1]) begin
      gnt_sel_s = rr_r;
    end else begin
      gnt_sel_s = nonempty_s[1];
    end
    pop_s[0] = gnt_any_s & ~gnt_sel_s;
    pop_s[1] = gnt_any_s &  gnt_sel_s;
  end

  // Queue entry storage (data path, no reset needed)
  always_ff @(posedge Clk) begin
    for (int n = 0; n < 2; n++) begin
      if (push_s[n]) begin
        q_addr[n][wptr_r[n]] <= req_addr[n];
        q_data[n][wptr_r[n]] <= req_data[n];
      end
    end
  end

  // Queue pointers, arbitration pointer and write-port registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int n = 0; n < 2; n++) begin
        wptr_r[n] <= '0;
        rptr_r[n] <= '0;
        cnt_r[n]  <= '0;
      end
      rr_r    <= 1'b0;
      rw_r    <= '0;
      busw_r  <= '0;
      regwr_r <= 1'b0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (push_s[n]) begin
          wptr_r[n] <= wptr_r[n] + PTR_ONE;
        end
        if (pop_s[n]) begin
          rptr_r[n] <= rptr_r[n] + PTR_ONE;
        end
        if (push_s[n] && !pop_s[n]) begin
          cnt_r[n] <= cnt_r[n] + CNT_ONE;
        end else if (!push_s[n] && pop_s[n]) begin
          cnt_r[n] <= cnt_r[n] - CNT_ONE;
        end
      end
      if (gnt_any_s) begin
        rw_r    <= q_addr[gnt_sel_s][rptr_r[gnt_sel_s]];
        busw_r  <= q_data[gnt_sel_s][rptr_r[gnt_sel_s]];
        regwr_r <= 1'b1;
        // Only a real contention moves the fairness pointer
        if (nonempty_s[0] && nonempty_s[1]) begin
          rr_r <= ~rr_r;
        end
      end else begin
        regwr_r <= 1'b0;
      end
    end
  end

  // Pending mask: every live queue entry plus the write in flight
  always_comb begin
    pending_s = '0;
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        // Entry i is live when its distance from the read pointer is
        // below the occupancy count (modulo queue depth).
        pending_s[q_addr[n][i]] = pending_s[q_addr[n][i]] |
          ((PTR_W+1)'(PTR_W'(PTR_W'(i) - rptr_r[n])) < cnt_r[n]);
      end
    end
    pending_s[rw_r] = pending_s[rw_r] | regwr_r;
  end

  assign bus.ReqReady0 = ready_s[0];
  assign bus.ReqReady1 = ready_s[1];
  assign bus.RW        = rw_r;
  assign bus.BusW      = busw_r;
  assign bus.RegWr     = regwr_r;
  assign bus.Pending   = Reset ? '0 : pending_s;
  assign bus.Idle      = Reset | (!nonempty_s[0] && !nonempty_s[1] && !regwr_r);
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
//   Directed bench for regfile_write_arbiter with a behavioural 32x64
//   register file that captures on the falling clock edge.
module tb_regfile_write_arbiter;
  logic Clk = 1'b0;
  logic Reset;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;
  int   cyc     = 0;

  regfile_write_arbiter_if #(.DATA_W(64), .ADDR_W(5)) bus ();

  regfile_write_arbiter #(
    .DATA_W(64), .ADDR_W(5), .FIFO_DEPTH(2), .ZERO_REG(31)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  // Register file model and write log
  logic [63:0] rf [32];
  bit          rf_clr = 1'b1;
  logic [4:0]  wlog [$];
  int          wcyc [$];

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= 64'd0;
    end else if (bus.RegWr) begin
      rf[bus.RW] <= bus.BusW;
    end
    if (bus.RegWr) begin
      wlog.push_back(bus.RW);
      wcyc.push_back(cyc);
    end
  end

  function automatic logic [63:0] rf_read(input int a);
    return (a == 31) ? 64'd0 : rf[a];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ReqValid0 = 1'b0; bus.ReqAddr0 = 5'd0; bus.ReqData0 = 64'd0;
    bus.ReqValid1 = 1'b0; bus.ReqAddr1 = 5'd0; bus.ReqData1 = 64'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  // Stimulus lists for the two requesters
  logic [4:0]  a0 [$];
  logic [63:0] d0 [$];
  logic [4:0]  a1 [$];
  logic [63:0] d1 [$];

  task automatic run_pair(output bit full0, output bit full1, output bit drained);
    int  i0 = 0;
    int  i1 = 0;
    bit  hs0, hs1;
    full0 = 1'b0; full1 = 1'b0; drained = 1'b0;
    for (int c = 0; c < 300 && !drained; c++) begin
      if (i0 >= a0.size() && i1 >= a1.size() && bus.Idle) begin
        drained = 1'b1;
      end else begin
        idle_inputs();
        if (i0 < a0.size()) begin
          bus.ReqValid0 = 1'b1; bus.ReqAddr0 = a0[i0]; bus.ReqData0 = d0[i0];
        end
        if (i1 < a1.size()) begin
          bus.ReqValid1 = 1'b1; bus.ReqAddr1 = a1[i1]; bus.ReqData1 = d1[i1];
        end
        #1;
        if (!bus.ReqReady0) full0 = 1'b1;
        if (!bus.ReqReady1) full1 = 1'b1;
        hs0 = bus.ReqValid0 && bus.ReqReady0;
        hs1 = bus.ReqValid1 && bus.ReqReady1;
        step();
        if (hs0) i0++;
        if (hs1) i1++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    logic [4:0] exp_rw [8];
    bit f0, f1, dr, all_ready;
    int base;

    idle_inputs();
    Reset = 1'b1;
    step();
    step();
    rf_clr = 1'b0;

    // Reset state while Reset is high
    check("rst_ready0",  64'(bus.ReqReady0), 64'd0);
    check("rst_ready1",  64'(bus.ReqReady1), 64'd0);
    check("rst_pending", 64'(bus.Pending),   64'd0);
    check("rst_idle",    64'(bus.Idle),      64'd1);
    check("rst_regwr",   64'(bus.RegWr),     64'd0);
    check("rst_rw",      64'(bus.RW),        64'd0);
    check("rst_busw",    bus.BusW,           64'd0);
    Reset = 1'b0;

    // Test 1: single write, latency and pending window
    bus.ReqValid0 = 1'b1; bus.ReqAddr0 = 5'd5; bus.ReqData0 = 64'h55;
    #1;
    check("t1_ready0", 64'(bus.ReqReady0), 64'd1);
    step();
    idle_inputs();
    check("t1_regwr_k",   64'(bus.RegWr),      64'd0);
    check("t1_pend_k",    64'(bus.Pending),    64'h20);
    check("t1_idle_k",    64'(bus.Idle),       64'd0);
    step();
    check("t1_regwr_k1",  64'(bus.RegWr),      64'd1);
    check("t1_rw_k1",     64'(bus.RW),         64'd5);
    check("t1_busw_k1",   bus.BusW,            64'h55);
    check("t1_pend_k1",   64'(bus.Pending),    64'h20);
    step();
    check("t1_regwr_k2",  64'(bus.RegWr),      64'd0);
    check("t1_rw_hold",   64'(bus.RW),         64'd5);
    check("t1_pend_k2",   64'(bus.Pending),    64'd0);
    check("t1_idle_k2",   64'(bus.Idle),       64'd1);
    check("t1_rf_x5",     rf_read(5),          64'h55);

    // Test 2: two-way contention, alternating grants
    do_reset();
    base = wlog.size();
    a0 = '{5'd1, 5'd2, 5'd3, 5'd4};
    d0 = '{64'hA1, 64'hA2, 64'hA3, 64'hA4};
    a1 = '{5'd11, 5'd12, 5'd13, 5'd14};
    d1 = '{64'hB1, 64'hB2, 64'hB3, 64'hB4};
    run_pair(f0, f1, dr);
    check("t2_drained",  64'(dr), 64'd1);
    check("t2_full0",    64'(f0), 64'd1);
    check("t2_full1",    64'(f1), 64'd1);
    check("t2_nwrites",  64'(wlog.size() - base), 64'd8);
    exp_rw = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};
    for (int k = 0; k < 8; k++) begin
      if (base + k < wlog.size())
        check($sformatf("t2_rw%0d", k), 64'(wlog[base + k]), 64'(exp_rw[k]));
      else
        check($sformatf("t2_rw%0d_missing", k), 64'd0, 64'(exp_rw[k]));
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_rf_x%0d", k + 1),  rf_read(k + 1),  64'hA1 + 64'(k));
      check($sformatf("t2_rf_x%0d", k + 11), rf_read(k + 11), 64'hB1 + 64'(k));
    end

    // Test 3: write to the zero register is swallowed
    do_reset();
    base = wlog.size();
    bus.ReqValid1 = 1'b1; bus.ReqAddr1 = 5'd31; bus.ReqData1 = 64'h12345678;
    #1;
    check("t3_ready1", 64'(bus.ReqReady1), 64'd1);
    step();
    idle_inputs();
    check("t3_pend_k",  64'(bus.Pending), 64'd0);
    check("t3_regwr_k", 64'(bus.RegWr),   64'd0);
    check("t3_idle_k",  64'(bus.Idle),    64'd1);
    step();
    check("t3_regwr_k1", 64'(bus.RegWr), 64'd0);
    check("t3_nwrites",  64'(wlog.size() - base), 64'd0);
    check("t3_rf_x31",   rf_read(31), 64'd0);

    // Test 4: reset with two writes still queued in requester 0
    do_reset();
    bus.ReqValid0 = 1'b1; bus.ReqAddr0 = 5'd16; bus.ReqData0 = 64'h16;
    bus.ReqValid1 = 1'b1; bus.ReqAddr1 = 5'd17; bus.ReqData1 = 64'h17;
    step();
    bus.ReqAddr0 = 5'd18; bus.ReqData0 = 64'h18;
    bus.ReqAddr1 = 5'd19; bus.ReqData1 = 64'h19;
    step();
    bus.ReqValid1 = 1'b0;
    bus.ReqAddr0 = 5'd20; bus.ReqData0 = 64'h20;
    step();
    idle_inputs();
    check("t4_ready0_full", 64'(bus.ReqReady0), 64'd0);
    check("t4_regwr",       64'(bus.RegWr),     64'd1);
    check("t4_rw",          64'(bus.RW),        64'd17);
    check("t4_pend_pre",    64'(bus.Pending),   64'h001E_0000);
    Reset = 1'b1;
    #1;
    check("t4_pend_inrst",  64'(bus.Pending),   64'd0);
    check("t4_idle_inrst",  64'(bus.Idle),      64'd1);
    step();
    Reset = 1'b0;
    check("t4_regwr_post",  64'(bus.RegWr),     64'd0);
    check("t4_pend_post",   64'(bus.Pending),   64'd0);
    check("t4_idle_post",   64'(bus.Idle),      64'd1);
    step();
    step();
    check("t4_rf_x16", rf_read(16), 64'h16);
    check("t4_rf_x17", rf_read(17), 64'h17);
    check("t4_rf_x18", rf_read(18), 64'd0);
    check("t4_rf_x19", rf_read(19), 64'd0);
    check("t4_rf_x20", rf_read(20), 64'd0);

    // Test 5: lone requester at full rate
    do_reset();
    base = wlog.size();
    all_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.ReqValid0 = 1'b1; bus.ReqAddr0 = 5'(i + 1); bus.ReqData0 = 64'hC0 + 64'(i);
      #1;
      if (!bus.ReqReady0) all_ready = 1'b0;
      step();
    end
    idle_inputs();
    for (int c = 0; c < 20 && !bus.Idle; c++) step();
    check("t5_idle",      64'(bus.Idle),  64'd1);
    check("t5_allready",  64'(all_ready), 64'd1);
    check("t5_nwrites",   64'(wlog.size() - base), 64'd8);
    if (wlog.size() - base == 8) begin
      check("t5_consecutive", 64'(wcyc[base + 7] - wcyc[base]), 64'd7);
      for (int k = 0; k < 8; k++)
        check($sformatf("t5_rw%0d", k), 64'(wlog[base + k]), 64'(k + 1));
    end
    check("t5_rf_x8", rf_read(8), 64'hC7);

    // Test 6: fill X0..X30 with their index through both requesters
    do_reset();
    a0.delete(); d0.delete(); a1.delete(); d1.delete();
    for (int i = 0; i < 31; i++) begin
      if (i % 2 == 0) begin
        a0.push_back(5'(i)); d0.push_back(64'(i));
      end else begin
        a1.push_back(5'(i)); d1.push_back(64'(i));
      end
    end
    run_pair(f0, f1, dr);
    check("t6_drained", 64'(dr), 64'd1);
    for (int i = 0; i < 32; i++)
      check($sformatf("t6_rf_x%0d", i), rf_read(i), (i == 31) ? 64'd0 : 64'(i));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
